l2_req_arbiter: RTL and testbench
=================================

Name: l2_req_arbiter

Overview:
- Shares the single L2 cache request port between three requesters: icache misses, dcache misses and writebacks, and a one-entry next-line instruction prefetch slot.
- Sits between the two L1 caches and level_two_cache, in place of the two-way arbiter, and adds prefetch injection.
- Keeps one L2 transaction outstanding at a time.
- Priority is dcache over icache, with a starvation guard for icache. Prefetches use only idle port slots.

Parameters:
STARVE_MAX, 4, consecutive dcache grants allowed while an icache request waits; after that the icache is forced ahead.
LINE_OFFSET, 5, number of byte-offset bits in a 32-byte line; line address is addr[31:LINE_OFFSET].

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_pmem_read  in  1  icache line read request, held until i_pmem_resp
i_pmem_address  in  32  icache request address
i_pmem_resp  out  1  one-cycle completion pulse to icache
i_pmem_rdata  out  256  line data to icache, valid while i_pmem_resp is high
d_pmem_read  in  1  dcache line read request
d_pmem_write  in  1  dcache line writeback request; never asserted together with d_pmem_read
d_pmem_address  in  32  dcache request address
d_pmem_wdata  in  256  dcache writeback line
d_pmem_resp  out  1  one-cycle completion pulse to dcache
d_pmem_rdata  out  256  line data to dcache, valid while d_pmem_resp is high
pf_valid  in  1  pulse: capture pf_address into the prefetch slot
pf_address  in  32  prefetch target address
pf_drop  out  1  pulse: pending prefetch discarded, not issued
ab_pmem_read  out  1  read request to L2
ab_pmem_write  out  1  write request to L2
ab_pmem_address  out  32  registered L2 request address
ab_pmem_wdata  out  256  registered L2 write line
ab_pmem_resp  in  1  L2 completion pulse
ab_pmem_rdata  in  256  L2 read line

Behaviour:
- Reset (asynchronous, reset_n low) forces the following, whatever transaction is in flight:
  - state IDLE;
  - all outputs 0;
  - prefetch slot empty;
  - starve_cnt 0.
- The L2 is reset by the same signal, so any in-flight response is lost by design.
- States: IDLE, BUSY_I, BUSY_D, BUSY_PF.
- IDLE arbitration is evaluated in cycle N. Order:
  1. icache, if i_pmem_read is high and starve_cnt equals STARVE_MAX;
  2. dcache, if d_pmem_read or d_pmem_write is high;
  3. icache, if i_pmem_read is high;
  4. prefetch, if the slot is valid;
  5. otherwise stay in IDLE.
- On grant:
  - latch the winner's address and wdata into the ab_* registers;
  - for a prefetch, force address[LINE_OFFSET-1:0] to 0.
- ab_pmem_read or ab_pmem_write is high from cycle N+1 until the cycle in which ab_pmem_resp is high, inclusive.
- In BUSY_x, when ab_pmem_resp is high:
  - the owner's *_resp goes high combinationally in the same cycle;
  - *_rdata passes ab_pmem_rdata through;
  - the next state is IDLE.
- BUSY_PF drives no resp to either cache. The fetched line goes into L2 only.
- Every transaction is followed by at least one IDLE cycle. This is mandatory so that requests deassert before arbitration.
- Minimum turnaround: request in cycle N, L2 read in N+1, resp in cycle M, next grant decision at M+1.
- starve_cnt (3-bit saturating):
  - +1 on a dcache grant while i_pmem_read is high;
  - cleared on an icache grant;
  - otherwise held.
- Prefetch slot:
  - pf_valid captures the line address and sets valid.
  - A capture while the slot is valid overwrites the old entry and pulses pf_drop for the old entry.
  - The slot is cleared on a prefetch grant.
  - On an icache grant whose line address matches the slot, the slot is cleared and pf_drop pulses. The demand fetch replaces the prefetch.
  - pf_valid in the same cycle as a slot clear: the capture wins and the slot stays valid with the new address. A pf_valid whose line matches the current slot neither drops nor changes the slot.
- An in-flight prefetch (BUSY_PF) is never cancelled. Demand requests wait until it completes.
- *_pmem_resp is high only in BUSY_x of the matching owner and only while ab_pmem_resp is high. A spurious ab_pmem_resp in IDLE is ignored.
- ab_pmem_read and ab_pmem_write are never high together.

Decomposition:
- Package arb_pkg:
  - state enum arb_state_t {IDLE, BUSY_I, BUSY_D, BUSY_PF};
  - requester enum req_id_t {REQ_I, REQ_D, REQ_PF};
  - line_addr_t (32-LINE_OFFSET bits).
- Sub-module pf_slot: one-entry prefetch register with capture, clear, match-drop and pf_drop generation.
- The FSM, starvation counter and output registers stay in the top module.

Test Plan:
- Icache read only: i_pmem_read with address 0x0000_1040, L2 resp 3 cycles after grant. Required: ab_pmem_read high with ab_pmem_address 0x0000_1040, i_pmem_resp for exactly 1 cycle, d_pmem_resp stays 0.
- Simultaneous requests: icache read and dcache write assert together. Required: the dcache is served first with ab_pmem_write and ab_pmem_wdata equal to the dcache line; the icache is granted after one IDLE cycle.
- Starvation: keep d_pmem_read back-to-back with i_pmem_read held. Required: exactly 4 dcache grants, then an icache grant, and starve_cnt returns to 0.
- Prefetch idle injection: pf_valid with address 0x0000_2044 and no other requests. Required: ab_pmem_read with address 0x0000_2040, no cache resp, pf_drop stays 0.
- Prefetch merge: prefetch slot holds 0x0000_3000, then an icache read to 0x0000_3010 arrives. Required: icache granted, pf_drop pulses, and no prefetch is issued afterwards.
- Reset mid-transaction: drive reset_n low during BUSY_D. Required: all outputs 0 immediately and state IDLE; after release, a new icache request is granted normally.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the L2 request arbiter: FSM states, requester ids and line-address helpers.
package arb_pkg;

  localparam int unsigned StarveMaxDef  = 4;
  localparam int unsigned LineOffsetDef = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    BUSY_PF
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_I,
    REQ_D,
    REQ_PF
  } req_id_t;

  typedef logic [32-LineOffsetDef-1:0] line_addr_t;

  // Mask that keeps the line-address bits of a byte address.
  function automatic logic [31:0] line_mask(input int unsigned offset);
    return ~((32'd1 << offset) - 32'd1);
  endfunction

endpackage

// File: rtl/pf_slot.sv
// One-entry prefetch slot: holds a pending prefetch until it is issued, superseded by a newer
// capture, or absorbed by a demand fetch of the same line.
module pf_slot
  import arb_pkg::*;
#(
  parameter int unsigned LINE_OFFSET = LineOffsetDef
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        capture_i,
  input  logic [31:0] capture_addr_i,
  input  logic        issue_i,
  input  logic        demand_i,
  input  logic [31:0] demand_addr_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic        drop_o
);

  localparam logic [31:0] LineMask = line_mask(LINE_OFFSET);

  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic        cap_match, dem_match;

  assign cap_match = valid_q && (((capture_addr_i ^ addr_q) & LineMask) == 32'd0);
  assign dem_match = demand_i && valid_q && (((demand_addr_i ^ addr_q) & LineMask) == 32'd0);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    drop_d  = 1'b0;
    if (capture_i) begin
      // A capture always leaves the slot valid; a same-line capture keeps the old entry.
      valid_d = 1'b1;
      if (!cap_match) begin
        addr_d = capture_addr_i;
      end
      // An entry being issued this cycle is not lost, so it is not reported as dropped.
      drop_d = valid_q && !cap_match && !issue_i;
    end else if (issue_i || dem_match) begin
      valid_d = 1'b0;
      drop_d  = dem_match;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= 32'd0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q & LineMask;
  assign drop_o  = drop_q;

endmodule

// File: rtl/l2_req_arbiter.sv
// Shares the single L2 request port between icache, dcache and a next-line prefetch slot,
// one transaction in flight, dcache first with an icache starvation guard.
module l2_req_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX  = StarveMaxDef,
  parameter int unsigned LINE_OFFSET = LineOffsetDef
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic         i_pmem_resp,
  output logic [255:0] i_pmem_rdata,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic         d_pmem_resp,
  output logic [255:0] d_pmem_rdata,
  input  logic         pf_valid,
  input  logic [31:0]  pf_address,
  output logic         pf_drop,
  output logic         ab_pmem_read,
  output logic         ab_pmem_write,
  output logic [31:0]  ab_pmem_address,
  output logic [255:0] ab_pmem_wdata,
  input  logic         ab_pmem_resp,
  input  logic [255:0] ab_pmem_rdata
);

  arb_state_t   state_q, state_d;
  logic [2:0]   starve_cnt_q, starve_cnt_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wdata_q, wdata_d;

  logic         grant;
  req_id_t      win;
  logic         slot_valid;
  logic [31:0]  slot_addr;

  pf_slot #(
    .LINE_OFFSET(LINE_OFFSET)
  ) u_pf_slot (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .capture_i     (pf_valid),
    .capture_addr_i(pf_address),
    .issue_i       (grant && (win == REQ_PF)),
    .demand_i      (grant && (win == REQ_I)),
    .demand_addr_i (i_pmem_address),
    .valid_o       (slot_valid),
    .addr_o        (slot_addr),
    .drop_o        (pf_drop)
  );

  // Arbitration, only meaningful in IDLE.
  always_comb begin
    grant = 1'b0;
    win   = REQ_I;
    if (state_q == IDLE) begin
      if (i_pmem_read && (starve_cnt_q == 3'(STARVE_MAX))) begin
        grant = 1'b1;
        win   = REQ_I;
      end else if (d_pmem_read || d_pmem_write) begin
        grant = 1'b1;
        win   = REQ_D;
      end else if (i_pmem_read) begin
        grant = 1'b1;
        win   = REQ_I;
      end else if (slot_valid) begin
        grant = 1'b1;
        win   = REQ_PF;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          case (win)
            REQ_I: begin
              state_d      = BUSY_I;
              rd_d         = 1'b1;
              wr_d         = 1'b0;
              addr_d       = i_pmem_address;
              wdata_d      = '0;
              starve_cnt_d = 3'd0;
            end
            REQ_D: begin
              state_d = BUSY_D;
              // Write wins if both are ever raised, keeping read/write exclusive on L2.
              rd_d    = d_pmem_read && !d_pmem_write;
              wr_d    = d_pmem_write;
              addr_d  = d_pmem_address;
              wdata_d = d_pmem_wdata;
              if (i_pmem_read && (starve_cnt_q != 3'd7)) begin
                starve_cnt_d = starve_cnt_q + 3'd1;
              end
            end
            default: begin
              state_d = BUSY_PF;
              rd_d    = 1'b1;
              wr_d    = 1'b0;
              addr_d  = slot_addr;
              wdata_d = '0;
            end
          endcase
        end
      end
      BUSY_I, BUSY_D, BUSY_PF: begin
        // Returning to IDLE for a cycle lets the finished requester drop its request.
        if (ab_pmem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= 3'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign ab_pmem_read    = rd_q;
  assign ab_pmem_write   = wr_q;
  assign ab_pmem_address = addr_q;
  assign ab_pmem_wdata   = wdata_q;

  assign i_pmem_resp  = (state_q == BUSY_I) && ab_pmem_resp;
  assign d_pmem_resp  = (state_q == BUSY_D) && ab_pmem_resp;
  assign i_pmem_rdata = i_pmem_resp ? ab_pmem_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? ab_pmem_rdata : '0;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: cache agents, an L2 model with programmable latency,
// and a grant/response scoreboard fed by a vector table and a few hand-written sequences.
module tb_l2_req_arbiter;
  import arb_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic         i_pmem_resp;
  logic [255:0] i_pmem_rdata;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic         d_pmem_resp;
  logic [255:0] d_pmem_rdata;
  logic         pf_valid;
  logic [31:0]  pf_address;
  logic         pf_drop;
  logic         ab_pmem_read;
  logic         ab_pmem_write;
  logic [31:0]  ab_pmem_address;
  logic [255:0] ab_pmem_wdata;
  logic         ab_pmem_resp;
  logic [255:0] ab_pmem_rdata;

  l2_req_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_resp    (i_pmem_resp),
    .i_pmem_rdata   (i_pmem_rdata),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_resp    (d_pmem_resp),
    .d_pmem_rdata   (d_pmem_rdata),
    .pf_valid       (pf_valid),
    .pf_address     (pf_address),
    .pf_drop        (pf_drop),
    .ab_pmem_read   (ab_pmem_read),
    .ab_pmem_write  (ab_pmem_write),
    .ab_pmem_address(ab_pmem_address),
    .ab_pmem_wdata  (ab_pmem_wdata),
    .ab_pmem_resp   (ab_pmem_resp),
    .ab_pmem_rdata  (ab_pmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    req_id_t      owner;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         b2b;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
  } dreq_t;

  typedef struct {
    logic        i_rd;
    logic [31:0] i_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic        pf;
    logic [31:0] pf_addr;
    int          lat;
    req_id_t     ord[3];
    int          n_ord;
    int          exp_drop;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] i_pend[$];
  dreq_t       d_pend[$];
  vec_t        vecs[8];

  int          n_pass = 0;
  int          n_total = 0;
  int          drop_cnt = 0;
  int          l2_lat = 3;
  int          l2_cnt = 0;
  int          cyc = 0;
  int          last_resp_cyc = -100;
  req_id_t     cur_owner = REQ_I;
  logic [31:0] cur_addr = 32'd0;
  logic        prev_req = 1'b0;
  logic        i_got, d_got;

  function automatic logic [255:0] line_data(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_C3C3}};
  endfunction

  function automatic logic [255:0] wdata_of(input logic [31:0] a);
    return {8{~a}};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic exp_t mk_exp(input req_id_t o, input vec_t v, input logic b2b);
    exp_t e;
    e.owner = o;
    e.b2b   = b2b;
    e.wr    = 1'b0;
    e.wdata = '0;
    case (o)
      REQ_I:   e.addr = v.i_addr;
      REQ_D: begin
        e.addr  = v.d_addr;
        e.wr    = v.d_wr;
        e.wdata = wdata_of(v.d_addr);
      end
      default: e.addr = {v.pf_addr[31:5], 5'b0};
    endcase
    return e;
  endfunction

  function automatic exp_t mk_one(input req_id_t o, input logic wr, input logic [31:0] a,
                                  input logic b2b);
    exp_t e;
    e.owner = o;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = wdata_of(a);
    e.b2b   = b2b;
    return e;
  endfunction

  // L2 model: responds l2_lat cycles into each request.
  initial begin
    ab_pmem_resp  = 1'b0;
    ab_pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        ab_pmem_resp = 1'b0;
        l2_cnt       = 0;
      end else if (ab_pmem_resp) begin
        ab_pmem_resp = 1'b0;
        l2_cnt       = 0;
      end else if (ab_pmem_read || ab_pmem_write) begin
        l2_cnt++;
        if (l2_cnt >= l2_lat) begin
          ab_pmem_resp  = 1'b1;
          ab_pmem_rdata = line_data(ab_pmem_address);
        end
      end else begin
        l2_cnt = 0;
      end
    end
  end

  // Icache agent.
  initial begin
    i_pmem_read    = 1'b0;
    i_pmem_address = 32'd0;
    forever begin
      @(negedge clk);
      i_got = i_pmem_resp;
      @(posedge clk);
      #1;
      if (!reset_n) begin
        i_pmem_read = 1'b0;
        i_pend.delete();
      end else begin
        if (i_got && i_pmem_read) begin
          i_pmem_read = 1'b0;
          void'(i_pend.pop_front());
        end
        if (!i_pmem_read && i_pend.size() > 0) begin
          i_pmem_read    = 1'b1;
          i_pmem_address = i_pend[0];
        end
      end
    end
  end

  // Dcache agent.
  initial begin
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = 32'd0;
    d_pmem_wdata   = '0;
    forever begin
      @(negedge clk);
      d_got = d_pmem_resp;
      @(posedge clk);
      #1;
      if (!reset_n) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        d_pend.delete();
      end else begin
        if (d_got && (d_pmem_read || d_pmem_write)) begin
          d_pmem_read  = 1'b0;
          d_pmem_write = 1'b0;
          void'(d_pend.pop_front());
        end
        if (!d_pmem_read && !d_pmem_write && d_pend.size() > 0) begin
          d_pmem_read    = !d_pend[0].wr;
          d_pmem_write   = d_pend[0].wr;
          d_pmem_address = d_pend[0].addr;
          d_pmem_wdata   = wdata_of(d_pend[0].addr);
        end
      end
    end
  end

  // Monitor: checks each grant against the scoreboard and each L2 response's routing.
  initial begin
    logic  req;
    exp_t  e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        prev_req = 1'b0;
      end else begin
        if (pf_drop) drop_cnt++;
        req = ab_pmem_read || ab_pmem_write;
        if (req && !prev_req) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_grant: got request to %h, required none", ab_pmem_address);
          end else begin
            e = exp_q.pop_front();
            check("grant_rw", {ab_pmem_read, ab_pmem_write}, {!e.wr, e.wr});
            check("grant_addr", ab_pmem_address, e.addr);
            if (e.wr) check("grant_wdata", ab_pmem_wdata, e.wdata);
            if (e.b2b) check("turnaround", cyc - last_resp_cyc, 2);
            cur_owner = e.owner;
            cur_addr  = e.addr;
          end
        end
        if (ab_pmem_resp && req) begin
          check("i_resp", i_pmem_resp, cur_owner == REQ_I);
          check("d_resp", d_pmem_resp, cur_owner == REQ_D);
          if (cur_owner == REQ_I) check("i_rdata", i_pmem_rdata, line_data(cur_addr));
          if (cur_owner == REQ_D) check("d_rdata", d_pmem_rdata, line_data(cur_addr));
          last_resp_cyc = cyc;
        end else if (i_pmem_resp || d_pmem_resp) begin
          n_total++;
          $display("FAIL stray_resp: got i=%0b d=%0b, required 0", i_pmem_resp, d_pmem_resp);
        end
        prev_req = req;
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || i_pend.size() != 0 || d_pend.size() != 0 ||
            ab_pmem_read || ab_pmem_write) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, n < budget, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (!(ab_pmem_read || ab_pmem_write) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, n < budget, 1'b1);
  endtask

  task automatic pulse_pf(input logic [31:0] a);
    @(posedge clk);
    #1;
    pf_valid   = 1'b1;
    pf_address = a;
    @(posedge clk);
    #1;
    pf_valid = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, {ab_pmem_read, ab_pmem_write, i_pmem_resp, d_pmem_resp, pf_drop}, 0);
    check({name, "_addr"}, ab_pmem_address, 0);
    check({name, "_wdata"}, ab_pmem_wdata, 0);
    check({name, "_rdata"}, i_pmem_rdata | d_pmem_rdata, 0);
    check({name, "_state"}, dut.state_q, IDLE);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    l2_lat   = v.lat;
    drop_cnt = 0;
    @(negedge clk);
    for (int k = 0; k < v.n_ord; k++) exp_q.push_back(mk_exp(v.ord[k], v, k > 0));
    if (v.i_rd) i_pend.push_back(v.i_addr);
    if (v.d_rd || v.d_wr) d_pend.push_back('{wr: v.d_wr, addr: v.d_addr});
    @(posedge clk);
    #1;
    if (v.pf) begin
      pf_valid   = 1'b1;
      pf_address = v.pf_addr;
    end
    @(posedge clk);
    #1;
    pf_valid = 1'b0;
    wait_done($sformatf("vec%0d", idx), 200);
    check($sformatf("vec%0d_pf_drop", idx), drop_cnt, v.exp_drop);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    pf_valid   = 1'b0;
    pf_address = 32'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;

    //           i_rd  i_addr         d_rd  d_wr  d_addr         pf    pf_addr      lat order                   n  drop
    vecs[0] = '{1'b1, 32'h0000_1040, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        3, '{REQ_I,  REQ_I, REQ_I},  1, 0};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_8000, 1'b0, 32'h0,        2, '{REQ_D,  REQ_I, REQ_I},  1, 0};
    vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_8020, 1'b0, 32'h0,        4, '{REQ_D,  REQ_I, REQ_I},  1, 0};
    vecs[3] = '{1'b1, 32'h0000_1100, 1'b0, 1'b1, 32'h0000_9000, 1'b0, 32'h0,        3, '{REQ_D,  REQ_I, REQ_I},  2, 0};
    vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_2044, 3, '{REQ_PF, REQ_I, REQ_I},  1, 0};
    vecs[5] = '{1'b1, 32'h0000_4000, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_5008, 2, '{REQ_I,  REQ_PF, REQ_I}, 2, 0};
    vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_A000, 1'b1, 32'h0000_B01C, 5, '{REQ_D,  REQ_PF, REQ_I}, 2, 0};
    vecs[7] = '{1'b1, 32'h0000_C000, 1'b1, 1'b0, 32'h0000_D000, 1'b1, 32'h0000_E000, 1, '{REQ_D,  REQ_I, REQ_PF},  3, 0};

    for (int v = 0; v < 8; v++) run_vec(vecs[v], v);

    // Starvation: six back-to-back dcache reads against one waiting icache read.
    l2_lat = 2;
    @(negedge clk);
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_one(REQ_D, 1'b0, 32'h0001_0000 + k * 32, k > 0));
    exp_q.push_back(mk_one(REQ_I, 1'b0, 32'h0002_0000, 1'b1));
    for (int k = 4; k < 6; k++) exp_q.push_back(mk_one(REQ_D, 1'b0, 32'h0001_0000 + k * 32, 1'b1));
    for (int k = 0; k < 6; k++) d_pend.push_back('{wr: 1'b0, addr: 32'h0001_0000 + k * 32});
    i_pend.push_back(32'h0002_0000);
    wait_done("starve", 400);
    check("starve_cnt_zero", dut.starve_cnt_q, 0);

    // Merge: icache demand of the line waiting in the prefetch slot absorbs it.
    l2_lat   = 8;
    drop_cnt = 0;
    @(negedge clk);
    exp_q.push_back(mk_one(REQ_D, 1'b0, 32'h0003_4000, 1'b0));
    exp_q.push_back(mk_one(REQ_I, 1'b0, 32'h0000_3010, 1'b1));
    d_pend.push_back('{wr: 1'b0, addr: 32'h0003_4000});
    wait_req("merge_busy", 50);
    pulse_pf(32'h0000_3000);
    i_pend.push_back(32'h0000_3010);
    wait_done("merge", 200);
    check("merge_pf_drop", drop_cnt, 1);
    check("merge_slot_empty", dut.u_pf_slot.valid_q, 1'b0);

    // Overwrite: a newer prefetch drops the old one; a same-line one changes nothing.
    drop_cnt = 0;
    @(negedge clk);
    exp_q.push_back(mk_one(REQ_D, 1'b0, 32'h0005_0000, 1'b0));
    exp_q.push_back(mk_one(REQ_PF, 1'b0, 32'h0000_7000, 1'b1));
    d_pend.push_back('{wr: 1'b0, addr: 32'h0005_0000});
    wait_req("ovw_busy", 50);
    pulse_pf(32'h0000_6000);
    pulse_pf(32'h0000_7008);
    pulse_pf(32'h0000_7004);
    wait_done("overwrite", 200);
    check("overwrite_pf_drop", drop_cnt, 1);

    // Reset in the middle of a dcache writeback.
    l2_lat = 30;
    @(negedge clk);
    exp_q.push_back(mk_one(REQ_D, 1'b1, 32'h0006_0000, 1'b0));
    d_pend.push_back('{wr: 1'b1, addr: 32'h0006_0000});
    wait_req("rst_busy", 50);
    check("rst_in_busy_d", dut.state_q, BUSY_D);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    l2_lat  = 3;
    @(negedge clk);
    exp_q.push_back(mk_one(REQ_I, 1'b0, 32'h0007_1080, 1'b0));
    i_pend.push_back(32'h0007_1080);
    wait_done("post_rst", 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
